// File: rtl/prio_encoder_stream.sv
// Streaming priority encoder: takes an N-bit request vector and emits the index of
// every set bit, highest first. Optional one-hot rejection is enabled with ENC_ONEHOT_CHECK_EN.
module prio_encoder_stream #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     w,
    input  logic             En,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] y,
    output logic             out_last,
    output logic             none
`ifdef ENC_ONEHOT_CHECK_EN
    ,
    output logic             err
`endif
);

    generate
        if ((N < 2) || ((N & (N - 1)) != 0) || (IDX_W != $clog2(N))) begin : g_bad_cfg
            $error("prio_encoder_stream: N must be a power of two >= 2 and IDX_W must equal log2(N)");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    localparam logic [N-1:0]     ZERO_V = {N{1'b0}};
    localparam logic [N-1:0]     LSB_V  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX0_V = {IDX_W{1'b0}};

    function automatic logic [IDX_W-1:0] hi_idx(input logic [N-1:0] v);
        hi_idx = IDX0_V;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                hi_idx = IDX_W'(i);
            end else begin
                hi_idx = hi_idx;
            end
        end
    endfunction

    function automatic logic is_onehot(input logic [N-1:0] v);
        is_onehot = (v != ZERO_V) && ((v & (v - LSB_V)) == ZERO_V);
    endfunction

    state_t             state_q, state_d;
    logic [N-1:0]       pend_q, pend_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [IDX_W-1:0]   y_q, y_d;
    logic               last_q, last_d;
    logic               none_q, none_d;
    logic [N-1:0]       clr_s;
`ifdef ENC_ONEHOT_CHECK_EN
    logic               err_q, err_d;
`endif

    // Next-state and next-output computation; outputs follow pending bits only.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        last_d      = last_q;
        none_d      = 1'b0;
`ifdef ENC_ONEHOT_CHECK_EN
        err_d       = 1'b0;
`endif
        clr_s       = pend_q & ~(LSB_V << y_q);
        case (state_q)
            S_IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                y_d         = IDX0_V;
                last_d      = 1'b0;
                pend_d      = ZERO_V;
                // in_ready_q gates acceptance so the first cycle after reset accepts nothing
                if (in_valid && in_ready_q) begin
                    if (!En || (w == ZERO_V)) begin
                        none_d = 1'b1;
`ifdef ENC_ONEHOT_CHECK_EN
                    end else if (!is_onehot(w)) begin
                        err_d = 1'b1;
`endif
                    end else begin
                        state_d     = S_STREAM;
                        pend_d      = w;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        y_d         = hi_idx(w);
                        last_d      = is_onehot(w);
                    end
                end else begin
                    none_d = 1'b0;
                end
            end
            S_STREAM: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b1;
                if (out_ready) begin
                    if (last_q) begin
                        state_d     = S_IDLE;
                        pend_d      = ZERO_V;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        y_d         = IDX0_V;
                        last_d      = 1'b0;
                    end else begin
                        pend_d = clr_s;
                        y_d    = hi_idx(clr_s);
                        last_d = is_onehot(clr_s);
                    end
                end else begin
                    pend_d = pend_q;
                end
            end
            default: begin
                state_d     = S_IDLE;
                pend_d      = ZERO_V;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                y_d         = IDX0_V;
                last_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset aborts any stream in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pend_q      <= ZERO_V;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= IDX0_V;
            last_q      <= 1'b0;
            none_q      <= 1'b0;
`ifdef ENC_ONEHOT_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            last_q      <= last_d;
            none_q      <= none_d;
`ifdef ENC_ONEHOT_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign out_last  = last_q;
    assign none      = none_q;
`ifdef ENC_ONEHOT_CHECK_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_prio_encoder_stream.sv
// Directed bench for prio_encoder_stream: reset, single/multi-bit vectors,
// back-pressure, empty/disabled vectors, mid-stream reset, optional one-hot check.
module tb_prio_encoder_stream;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] w;
    logic       En;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] y;
    logic       out_last;
    logic       none;
`ifdef ENC_ONEHOT_CHECK_EN
    logic       err;
`endif

    int errs   = 0;
    int checks = 0;

    prio_encoder_stream #(.N(4), .IDX_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w         (w),
        .En        (En),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_last  (out_last),
        .none      (none)
`ifdef ENC_ONEHOT_CHECK_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [1:0] ey, input logic elast);
        chk({tag, "_valid"}, 8'(out_valid), 8'd1);
        chk({tag, "_y"}, 8'(y), 8'(ey));
        chk({tag, "_last"}, 8'(out_last), 8'(elast));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; w = 4'b1111; En = 1'b1; out_ready = 1'b0;
        step(); step(); step();
        chk("rst_in_ready", 8'(in_ready), 8'd0);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_y", 8'(y), 8'd0);
        chk("rst_none", 8'(none), 8'd0);
        chk("rst_last", 8'(out_last), 8'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        chk("rel_in_ready", 8'(in_ready), 8'd1);
        chk("rel_out_valid", 8'(out_valid), 8'd0);
        step();
        chk("rel_out_valid2", 8'(out_valid), 8'd0);

        // single bit
        w = 4'b0100; En = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step(); in_valid = 1'b0;
        chk_beat("one", 2'd2, 1'b1);
        chk("one_in_ready_busy", 8'(in_ready), 8'd0);
        step();
        chk("one_done_valid", 8'(out_valid), 8'd0);
        chk("one_done_in_ready", 8'(in_ready), 8'd1);

        // three bits, no back-pressure
        w = 4'b1011; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        chk_beat("m0", 2'd3, 1'b0);
        step(); chk_beat("m1", 2'd1, 1'b0);
        step(); chk_beat("m2", 2'd0, 1'b1);
        step();
        chk("m_done_valid", 8'(out_valid), 8'd0);
        chk("m_done_in_ready", 8'(in_ready), 8'd1);

        // back-pressure
        w = 4'b1010; in_valid = 1'b1; out_ready = 1'b0;
        step(); in_valid = 1'b0;
        chk_beat("bp0", 2'd3, 1'b0);
        step(); chk_beat("bp1", 2'd3, 1'b0);
        step(); chk_beat("bp2", 2'd3, 1'b0);
        step(); chk_beat("bp3", 2'd3, 1'b0);
        out_ready = 1'b1;
        step(); chk_beat("bp4", 2'd1, 1'b1);
        step();
        chk("bp_done_valid", 8'(out_valid), 8'd0);

        // disabled and empty vectors
        w = 4'b0110; En = 1'b0; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        chk("dis_none", 8'(none), 8'd1);
        chk("dis_valid", 8'(out_valid), 8'd0);
        chk("dis_in_ready", 8'(in_ready), 8'd1);
        step();
        chk("dis_none_end", 8'(none), 8'd0);
        w = 4'b0000; En = 1'b1; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        chk("zero_none", 8'(none), 8'd1);
        chk("zero_valid", 8'(out_valid), 8'd0);
        step();
        chk("zero_none_end", 8'(none), 8'd0);
        chk("zero_valid_end", 8'(out_valid), 8'd0);

        // mid-stream reset
        w = 4'b1111; En = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step(); in_valid = 1'b0;
        chk_beat("mr0", 2'd3, 1'b0);
        step();
        chk_beat("mr1", 2'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mr_async_valid", 8'(out_valid), 8'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("mr_in_ready", 8'(in_ready), 8'd1);
        chk("mr_valid", 8'(out_valid), 8'd0);
        step();
        chk("mr_valid2", 8'(out_valid), 8'd0);

`ifdef ENC_ONEHOT_CHECK_EN
        w = 4'b0011; En = 1'b1; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        chk("oh_err", 8'(err), 8'd1);
        chk("oh_valid", 8'(out_valid), 8'd0);
        chk("oh_none", 8'(none), 8'd0);
        step();
        chk("oh_err_end", 8'(err), 8'd0);
        chk("oh_valid_end", 8'(out_valid), 8'd0);
        w = 4'b1000; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        chk_beat("oh_ok", 2'd3, 1'b1);
        chk("oh_ok_err", 8'(err), 8'd0);
        step();
        chk("oh_ok_done", 8'(out_valid), 8'd0);
`else
        w = 4'b0011; En = 1'b1; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        chk_beat("mh0", 2'd1, 1'b0);
        step(); chk_beat("mh1", 2'd0, 1'b1);
        step();
        chk("mh_done", 8'(out_valid), 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
